dram_width_bridge: RTL and testbench
====================================

DRAM_WIDTH_BRIDGE -- requirements
Module: dram_width_bridge

Interface
REQ-001 Parameter SDRAM_ADDR_BITS, default `MEM_ADDR_BITS + 1, half-word address width on the SDRAM side.
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 sync_reset  in  1  synchronous, active-high reset.
REQ-004 dram_mem_addr  in  `MEM_ADDR_BITS  32-bit word address from MCU.
REQ-005 dram_mem_read_en  in  1  one-cycle read request pulse.
REQ-006 dram_mem_write_en  in  1  one-cycle write request pulse.
REQ-007 dram_mem_byte_enable  in  `XLEN_BYTES  byte lanes for write.
REQ-008 dram_mem_write_data  in  `XLEN  write word.
REQ-009 dram_ack  out  1  one-cycle completion pulse to MCU.
REQ-010 dram_mem_read_data  out  `XLEN  assembled read word.
REQ-011 sdram_addr  out  SDRAM_ADDR_BITS  half-word address.
REQ-012 sdram_read / sdram_write  out  1 each  request strobes, held until accepted.
REQ-013 sdram_byteenable  out  2  half-word lanes.
REQ-014 sdram_writedata  out  16  write half-word.
REQ-015 sdram_waitrequest  in  1  high = request not accepted this cycle.
REQ-016 sdram_readdatavalid / sdram_readdata  in  1 / 16  read return beat, arbitrary latency, in order.

Function
REQ-017 States: IDLE, LO_REQ, HI_REQ, RD_WAIT, ACK.
REQ-018 IDLE: read_en or write_en latches addr, byte_enable, write_data, op type; next state LO_REQ.
REQ-019 read_en and write_en in the same cycle: treated as write.
REQ-020 Requests arriving outside IDLE are ignored; no queueing.
REQ-021 LO_REQ: sdram_addr = {addr,1'b0}, byteenable = BE[1:0], writedata = data[15:0]; strobe held while waitrequest=1; advance to HI_REQ in the cycle waitrequest=0.
REQ-022 HI_REQ: sdram_addr = {addr,1'b1}, byteenable = BE[3:2], writedata = data[31:16]; on acceptance write goes to ACK, read goes to RD_WAIT.
REQ-023 Reads drive byteenable = 2'b11 in both halves regardless of dram_mem_byte_enable.
REQ-024 A 2-bit beat counter counts readdatavalid beats of the current read; first beat fills read_data[15:0], second fills [31:16]; beats may arrive from the cycle after LO_REQ acceptance onward, including during HI_REQ.
REQ-025 RD_WAIT exits to ACK the cycle after the second beat is captured.
REQ-026 ACK: dram_ack = 1 for exactly one cycle, then IDLE; minimum write latency request-to-ack = 3 cycles with waitrequest=0.
REQ-027 dram_mem_read_data holds its last completed value until the next read completes; a write leaves it unchanged.
REQ-028 readdatavalid with no read outstanding, or a third beat, is ignored.
REQ-029 sdram_read and sdram_write are never high together; both low in IDLE, RD_WAIT, ACK.

Reset
REQ-030 sync_reset=1 forces IDLE, dram_ack=0, sdram_read=0, sdram_write=0, beat counter=0, dram_mem_read_data=0, sdram_addr=0, byteenable=0, writedata=0.
REQ-031 Reset mid-transaction abandons it with no ack; in-flight return beats afterwards are discarded per REQ-028.

Configuration
REQ-032 Macro DRAM_SKIP_EMPTY_HALF_EN.
REQ-033 Defined: a write half with byte enables 2'b00 issues no SDRAM request (LO skipped -> HI_REQ; HI skipped -> ACK); a write with BE=4'b0000 acks 1 cycle after IDLE.
REQ-034 Not defined: both halves always issued, including with byteenable 2'b00.

Verification
REQ-035 Write addr 0x10, BE 4'hF, data 0xDEADBEEF, waitrequest=0 -> writes (0x20,BE 3,0xBEEF),(0x21,BE 3,0xDEAD); ack 3 cycles after request.
REQ-036 Read addr 0x4, beats 0x5678 then 0x1234 at latency 4 -> dram_mem_read_data=0x12345678, one ack pulse.
REQ-037 waitrequest high 5 cycles during LO_REQ -> strobe, address, data stable all 5 cycles; no HI request until accepted.
REQ-038 Write BE 4'b1100 -> macro on: only half-address 2k+1 written; macro off: both halves, low with BE 2'b00.
REQ-039 sync_reset asserted in RD_WAIT after one beat, then two stray beats -> no ack, read_data=0, next read completes correctly.
REQ-040 Read_en and write_en same cycle, plus read_en during HI_REQ -> single write performed, extra request dropped, one ack.

Source files
------------

// File: rtl/dram_width_bridge_if.sv
// Bus interfaces for the DRAM width bridge.
//   dram_mem_if : 32-bit word-oriented MCU memory port (master = MCU, slave = bridge)
//   sdram_if    : 16-bit half-word SDRAM request/return port (master = bridge, slave = SDRAM)
// Width macros default here when the surrounding build does not provide them.

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 24
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_BYTES
`define XLEN_BYTES 4
`endif

interface dram_mem_if;
    logic [`MEM_ADDR_BITS-1:0] dram_mem_addr;
    logic                      dram_mem_read_en;
    logic                      dram_mem_write_en;
    logic [`XLEN_BYTES-1:0]    dram_mem_byte_enable;
    logic [`XLEN-1:0]          dram_mem_write_data;
    logic                      dram_ack;
    logic [`XLEN-1:0]          dram_mem_read_data;

    modport master (
        output dram_mem_addr, dram_mem_read_en, dram_mem_write_en,
               dram_mem_byte_enable, dram_mem_write_data,
        input  dram_ack, dram_mem_read_data
    );

    modport slave (
        input  dram_mem_addr, dram_mem_read_en, dram_mem_write_en,
               dram_mem_byte_enable, dram_mem_write_data,
        output dram_ack, dram_mem_read_data
    );
endinterface

interface sdram_if #(parameter int SDRAM_ADDR_BITS = `MEM_ADDR_BITS + 1);
    logic [SDRAM_ADDR_BITS-1:0] sdram_addr;
    logic                       sdram_read;
    logic                       sdram_write;
    logic [1:0]                 sdram_byteenable;
    logic [15:0]                sdram_writedata;
    logic                       sdram_waitrequest;
    logic                       sdram_readdatavalid;
    logic [15:0]                sdram_readdata;

    modport master (
        output sdram_addr, sdram_read, sdram_write, sdram_byteenable, sdram_writedata,
        input  sdram_waitrequest, sdram_readdatavalid, sdram_readdata
    );

    modport slave (
        input  sdram_addr, sdram_read, sdram_write, sdram_byteenable, sdram_writedata,
        output sdram_waitrequest, sdram_readdatavalid, sdram_readdata
    );
endinterface

// File: rtl/dram_width_bridge.sv
// dram_width_bridge: splits each 32-bit MCU access into two 16-bit SDRAM
// accesses (low half at {addr,0}, high half at {addr,1}) and reassembles reads.
// Optional feature macro DRAM_SKIP_EMPTY_HALF_EN: when defined, write halves
// whose two byte enables are both clear are not issued to the SDRAM.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for an MCU read/write pulse; request fields latched
// LO_REQ  | low half-word request on SDRAM, held until accepted
// HI_REQ  | high half-word request on SDRAM, held until accepted
// RD_WAIT | read: waiting for both return beats
// ACK     | one-cycle completion pulse to the MCU

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 24
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_BYTES
`define XLEN_BYTES 4
`endif

module dram_width_bridge #(
    parameter int SDRAM_ADDR_BITS = `MEM_ADDR_BITS + 1
) (
    input  logic      clk,
    input  logic      sync_reset,
    dram_mem_if.slave mem,
    sdram_if.master   sdram
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LO_REQ  = 3'd1,
        HI_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        ACK     = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [`MEM_ADDR_BITS-1:0] addr_q;
    logic [`XLEN_BYTES-1:0]    be_q;
    logic [`XLEN-1:0]          wdata_q;
    logic                      is_write_q;
    logic [1:0]                beat_cnt_q;
    logic [15:0]               rd_lo_q;
    logic [`XLEN-1:0]          rdata_q;

    logic                       req_any;
    logic                       beat_ok;
    logic [SDRAM_ADDR_BITS-1:0] sd_addr_d;
    logic                       sd_read_d;
    logic                       sd_write_d;
    logic [1:0]                 sd_be_d;
    logic [15:0]                sd_wdata_d;

    assign req_any = mem.dram_mem_read_en | mem.dram_mem_write_en;

    // Return beats belong to the current read only once its low half has been
    // accepted, and only the first two are used.
    assign beat_ok = sdram.sdram_readdatavalid && !is_write_q &&
                     (state_q == HI_REQ || state_q == RD_WAIT) &&
                     (beat_cnt_q != 2'd2);

    // State register.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
`ifdef DRAM_SKIP_EMPTY_HALF_EN
                    if (mem.dram_mem_write_en && mem.dram_mem_byte_enable[1:0] == 2'b00) begin
                        state_d = (mem.dram_mem_byte_enable[3:2] == 2'b00) ? ACK : HI_REQ;
                    end else begin
                        state_d = LO_REQ;
                    end
`else
                    state_d = LO_REQ;
`endif
                end
            end
            LO_REQ: begin
                if (!sdram.sdram_waitrequest) begin
`ifdef DRAM_SKIP_EMPTY_HALF_EN
                    state_d = (is_write_q && be_q[3:2] == 2'b00) ? ACK : HI_REQ;
`else
                    state_d = HI_REQ;
`endif
                end
            end
            HI_REQ: begin
                if (!sdram.sdram_waitrequest) begin
                    state_d = is_write_q ? ACK : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (beat_cnt_q == 2'd2) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SDRAM request outputs decoded from the current state; all zero outside the request states.
    always_comb begin
        sd_addr_d  = '0;
        sd_read_d  = 1'b0;
        sd_write_d = 1'b0;
        sd_be_d    = 2'b00;
        sd_wdata_d = 16'h0000;
        case (state_q)
            LO_REQ: begin
                sd_addr_d  = SDRAM_ADDR_BITS'({addr_q, 1'b0});
                sd_read_d  = !is_write_q;
                sd_write_d = is_write_q;
                sd_be_d    = is_write_q ? be_q[1:0] : 2'b11;
                sd_wdata_d = wdata_q[15:0];
            end
            HI_REQ: begin
                sd_addr_d  = SDRAM_ADDR_BITS'({addr_q, 1'b1});
                sd_read_d  = !is_write_q;
                sd_write_d = is_write_q;
                sd_be_d    = is_write_q ? be_q[3:2] : 2'b11;
                sd_wdata_d = wdata_q[31:16];
            end
            default: begin
            end
        endcase
    end

    assign sdram.sdram_addr       = sd_addr_d;
    assign sdram.sdram_read       = sd_read_d;
    assign sdram.sdram_write      = sd_write_d;
    assign sdram.sdram_byteenable = sd_be_d;
    assign sdram.sdram_writedata  = sd_wdata_d;
    assign mem.dram_ack           = (state_q == ACK);
    assign mem.dram_mem_read_data = rdata_q;

    // Request capture and read reassembly; the visible read word only changes
    // when the second beat lands, so a partial read never shows through.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            beat_cnt_q <= 2'd0;
            rd_lo_q    <= 16'h0000;
            rdata_q    <= '0;
        end else begin
            if (state_q == IDLE) begin
                beat_cnt_q <= 2'd0;
                if (req_any) begin
                    addr_q     <= mem.dram_mem_addr;
                    be_q       <= mem.dram_mem_byte_enable;
                    wdata_q    <= mem.dram_mem_write_data;
                    is_write_q <= mem.dram_mem_write_en;
                end
            end
            if (beat_ok) begin
                beat_cnt_q <= beat_cnt_q + 2'd1;
                if (beat_cnt_q == 2'd0) begin
                    rd_lo_q <= sdram.sdram_readdata;
                end else begin
                    rdata_q <= {sdram.sdram_readdata, rd_lo_q};
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_width_bridge.sv
// Directed bench for dram_width_bridge: write/read splitting, waitrequest
// stalls, byte-enable handling, reset abandonment and request dropping.

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 24
`endif

module tb_dram_width_bridge;

    logic clk;
    logic sync_reset;

    dram_mem_if mem();
    sdram_if #(.SDRAM_ADDR_BITS(`MEM_ADDR_BITS + 1)) sd();

    dram_width_bridge #(.SDRAM_ADDR_BITS(`MEM_ADDR_BITS + 1)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .mem        (mem),
        .sdram      (sd)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;
    int req_edge = 0;

    logic [31:0] log_addr[$];
    logic [1:0]  log_be[$];
    logic [15:0] log_data[$];
    logic        log_wr[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive SDRAM-side monitor: logs every accepted request and every ack.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!sync_reset) begin
            if ((sd.sdram_read || sd.sdram_write) && !sd.sdram_waitrequest) begin
                log_addr.push_back(32'(sd.sdram_addr));
                log_be.push_back(sd.sdram_byteenable);
                log_data.push_back(sd.sdram_writedata);
                log_wr.push_back(sd.sdram_write);
            end
            if (mem.dram_ack) begin
                ack_cnt = ack_cnt + 1;
                ack_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] data);
        mem.dram_mem_addr        = addr[`MEM_ADDR_BITS-1:0];
        mem.dram_mem_byte_enable = be;
        mem.dram_mem_write_data  = data;
        mem.dram_mem_read_en     = rd;
        mem.dram_mem_write_en    = wr;
        req_edge = cyc + 1;
        tick();
        mem.dram_mem_read_en  = 1'b0;
        mem.dram_mem_write_en = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int a0, input int budget);
        int n = 0;
        while (ack_cnt == a0 && n < budget) begin
            tick();
            n = n + 1;
        end
        check_eq(tag, 64'(ack_cnt - a0), 64'd1);
    endtask

    task automatic drive_beats(input int delay, input logic [15:0] d0, input logic [15:0] d1);
        repeat (delay) tick();
        sd.sdram_readdatavalid = 1'b1;
        sd.sdram_readdata      = d0;
        tick();
        sd.sdram_readdata      = d1;
        tick();
        sd.sdram_readdatavalid = 1'b0;
    endtask

    // Compares one logged SDRAM request; write data is only meaningful for writes.
    task automatic check_req(input string tag, input int idx, input logic [31:0] addr,
                             input logic [1:0] be, input logic [15:0] data, input logic wr);
        logic [63:0] obs;
        logic [63:0] exp;
        if (idx < log_addr.size()) begin
            obs = {13'd0, log_addr[idx], log_be[idx], (log_wr[idx] ? log_data[idx] : 16'h0), log_wr[idx]};
        end else begin
            obs = '1;
        end
        exp = {13'd0, addr, be, (wr ? data : 16'h0), wr};
        check_eq(tag, obs, exp);
    endtask

    int base;
    int a0;

    initial begin
        sync_reset                = 1'b1;
        mem.dram_mem_addr         = '0;
        mem.dram_mem_read_en      = 1'b0;
        mem.dram_mem_write_en     = 1'b0;
        mem.dram_mem_byte_enable  = '0;
        mem.dram_mem_write_data   = '0;
        sd.sdram_waitrequest      = 1'b0;
        sd.sdram_readdatavalid    = 1'b0;
        sd.sdram_readdata         = 16'h0000;
        repeat (3) tick();

        check_eq("rst_ack",   64'(mem.dram_ack), 64'd0);
        check_eq("rst_strb",  64'({sd.sdram_read, sd.sdram_write}), 64'd0);
        check_eq("rst_addr",  64'(sd.sdram_addr), 64'd0);
        check_eq("rst_be",    64'(sd.sdram_byteenable), 64'd0);
        check_eq("rst_wdata", 64'(sd.sdram_writedata), 64'd0);
        check_eq("rst_rdata", 64'(mem.dram_mem_read_data), 64'd0);
        sync_reset = 1'b0;
        tick();

        // Basic full write
        base = log_addr.size();
        a0 = ack_cnt;
        issue(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        wait_ack("wr_ack", a0, 20);
        check_eq("wr_lat", 64'(ack_cyc - req_edge), 64'd3);
        check_eq("wr_nreq", 64'(log_addr.size() - base), 64'd2);
        check_req("wr_lo", base,     32'h20, 2'b11, 16'hBEEF, 1'b1);
        check_req("wr_hi", base + 1, 32'h21, 2'b11, 16'hDEAD, 1'b1);
        repeat (3) tick();
        check_eq("wr_one_ack", 64'(ack_cnt - a0), 64'd1);

        // Basic read, beats arriving late
        base = log_addr.size();
        a0 = ack_cnt;
        issue(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
        fork
            drive_beats(3, 16'h5678, 16'h1234);
            wait_ack("rd_ack", a0, 30);
        join
        check_eq("rd_data", 64'(mem.dram_mem_read_data), 64'h12345678);
        check_req("rd_lo", base,     32'h8, 2'b11, 16'h0, 1'b0);
        check_req("rd_hi", base + 1, 32'h9, 2'b11, 16'h0, 1'b0);
        repeat (3) tick();
        check_eq("rd_one_ack", 64'(ack_cnt - a0), 64'd1);

        // Read with first beat during HI_REQ; old word must stay visible until completion
        a0 = ack_cnt;
        issue(1'b1, 1'b0, 32'h7, 4'hF, 32'h0);
        tick();
        sd.sdram_readdatavalid = 1'b1;
        sd.sdram_readdata      = 16'hAAAA;
        tick();
        check_eq("rd_hold", 64'(mem.dram_mem_read_data), 64'h12345678);
        sd.sdram_readdata      = 16'h5555;
        tick();
        sd.sdram_readdatavalid = 1'b0;
        wait_ack("rd2_ack", a0, 20);
        check_eq("rd2_data", 64'(mem.dram_mem_read_data), 64'h5555AAAA);

        // Waitrequest stall on the low half
        base = log_addr.size();
        a0 = ack_cnt;
        sd.sdram_waitrequest = 1'b1;
        issue(1'b0, 1'b1, 32'h3, 4'hF, 32'h11223344);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_lo", 64'({sd.sdram_write, sd.sdram_read, 32'(sd.sdram_addr), sd.sdram_byteenable, sd.sdram_writedata}),
                     64'({1'b1, 1'b0, 32'h6, 2'b11, 16'h3344}));
            tick();
        end
        check_eq("stall_nreq", 64'(log_addr.size() - base), 64'd0);
        sd.sdram_waitrequest = 1'b0;
        wait_ack("stall_ack", a0, 20);
        check_eq("stall_n", 64'(log_addr.size() - base), 64'd2);
        check_req("stall_lo_req", base,     32'h6, 2'b11, 16'h3344, 1'b1);
        check_req("stall_hi_req", base + 1, 32'h7, 2'b11, 16'h1122, 1'b1);
        check_eq("wr_keeps_rdata", 64'(mem.dram_mem_read_data), 64'h5555AAAA);

        // Partial byte enables
        base = log_addr.size();
        a0 = ack_cnt;
        issue(1'b0, 1'b1, 32'h8, 4'b1100, 32'hCAFEF00D);
        wait_ack("be_ack", a0, 20);
`ifdef DRAM_SKIP_EMPTY_HALF_EN
        check_eq("be_n", 64'(log_addr.size() - base), 64'd1);
        check_req("be_hi", base, 32'h11, 2'b11, 16'hCAFE, 1'b1);
        check_eq("be_lat", 64'(ack_cyc - req_edge), 64'd2);
`else
        check_eq("be_n", 64'(log_addr.size() - base), 64'd2);
        check_req("be_lo", base,     32'h10, 2'b00, 16'hF00D, 1'b1);
        check_req("be_hi", base + 1, 32'h11, 2'b11, 16'hCAFE, 1'b1);
        check_eq("be_lat", 64'(ack_cyc - req_edge), 64'd3);
`endif
        tick();

        base = log_addr.size();
        a0 = ack_cnt;
        issue(1'b0, 1'b1, 32'h9, 4'b0000, 32'h12345678);
        wait_ack("be0_ack", a0, 20);
`ifdef DRAM_SKIP_EMPTY_HALF_EN
        check_eq("be0_n", 64'(log_addr.size() - base), 64'd0);
        check_eq("be0_lat", 64'(ack_cyc - req_edge), 64'd1);
`else
        check_eq("be0_n", 64'(log_addr.size() - base), 64'd2);
        check_req("be0_lo", base,     32'h12, 2'b00, 16'h5678, 1'b1);
        check_req("be0_hi", base + 1, 32'h13, 2'b00, 16'h1234, 1'b1);
        check_eq("be0_lat", 64'(ack_cyc - req_edge), 64'd3);
`endif
        tick();

        // Reset in RD_WAIT after one beat, then stray beats
        a0 = ack_cnt;
        issue(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        tick();
        tick();
        sd.sdram_readdatavalid = 1'b1;
        sd.sdram_readdata      = 16'h9999;
        tick();
        sd.sdram_readdatavalid = 1'b0;
        sync_reset = 1'b1;
        tick();
        tick();
        sync_reset = 1'b0;
        sd.sdram_readdatavalid = 1'b1;
        sd.sdram_readdata      = 16'h7777;
        tick();
        sd.sdram_readdata      = 16'h6666;
        tick();
        sd.sdram_readdatavalid = 1'b0;
        repeat (3) tick();
        check_eq("rst_noack", 64'(ack_cnt - a0), 64'd0);
        check_eq("rst_rdata0", 64'(mem.dram_mem_read_data), 64'd0);
        check_eq("rst_idle", 64'({sd.sdram_read, sd.sdram_write}), 64'd0);

        base = log_addr.size();
        a0 = ack_cnt;
        issue(1'b1, 1'b0, 32'h5, 4'h0, 32'h0);
        fork
            drive_beats(2, 16'hBEEF, 16'hCAFE);
            wait_ack("post_rst_ack", a0, 30);
        join
        check_eq("post_rst_data", 64'(mem.dram_mem_read_data), 64'hCAFEBEEF);
        check_req("post_rst_lo", base,     32'hA, 2'b11, 16'h0, 1'b0);
        check_req("post_rst_hi", base + 1, 32'hB, 2'b11, 16'h0, 1'b0);

        // Simultaneous read+write is a write; a read during HI_REQ is dropped
        base = log_addr.size();
        a0 = ack_cnt;
        issue(1'b1, 1'b1, 32'h30, 4'hF, 32'h01020304);
        tick();
        issue(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        wait_ack("both_ack", a0, 20);
        repeat (6) tick();
        check_eq("both_one_ack", 64'(ack_cnt - a0), 64'd1);
        check_eq("both_n", 64'(log_addr.size() - base), 64'd2);
        check_req("both_lo", base,     32'h60, 2'b11, 16'h0304, 1'b1);
        check_req("both_hi", base + 1, 32'h61, 2'b11, 16'h0102, 1'b1);
        check_eq("both_rdata", 64'(mem.dram_mem_read_data), 64'hCAFEBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
